// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared decode constants and the EX-stage control bundle.
//   ALU_*        : 3-bit alucontrol encoding consumed by the EX-stage ALU
//   OP_*         : major opcodes understood by the ALU control decoder
//   TAG_MAXW     : storage width reserved for the opaque tag (TAGW <= TAG_MAXW)
//   ex_ctrl_t    : {alucontrol, alusrc_imm, regwrite, branch, illegal, tag}
//   funct3_to_alu: funct3 -> {legal, alucontrol} for R/I-type ALU ops
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // The bundle carries a fixed-width tag slot; the top uses the low TAGW bits.
  localparam int TAG_MAXW = 32;

  typedef struct packed {
    logic [2:0]          alucontrol;
    logic                alusrc_imm;
    logic                regwrite;
    logic                branch;
    logic                illegal;
    logic [TAG_MAXW-1:0] tag;
  } ex_ctrl_t;

  // Returns {legal, alucontrol}. sub_sel only matters for funct3=000.
  function automatic logic [3:0] funct3_to_alu(input logic [2:0] funct3,
                                               input logic       sub_sel);
    logic [3:0] res;
    case (funct3)
      3'b000:  res = {1'b1, (sub_sel ? ALU_SUB : ALU_ADD)};
      3'b111:  res = {1'b1, ALU_AND};
      3'b110:  res = {1'b1, ALU_OR};
      3'b100:  res = {1'b1, ALU_XOR};
      3'b010:  res = {1'b1, ALU_SLT};
      default: res = {1'b0, ALU_ADD};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// -----------------------------------------------------------------------------
// alu_ctrl_dec
// Pure combinational decoder: opcode/funct3/funct7[5] -> ex_ctrl_t.
// Ports:
//   op       in  [6:0]      instruction opcode
//   funct3   in  [2:0]      instruction [14:12]
//   funct7b5 in             instruction [30] (selects sub for R-type 000)
//   tag      in  [TAGW-1:0] opaque tag, passed through into ctrl.tag
//   ctrl     out ex_ctrl_t  decoded EX-stage control bundle
// Illegal decodes (unknown opcode, or funct3 001/011/101 on R/I) produce an
// add with regwrite=0 and branch=0, and set ctrl.illegal.
// -----------------------------------------------------------------------------
module alu_ctrl_dec
  import riscv_pkg::*;
#(
  parameter int TAGW = 5
) (
  input  logic [6:0]      op,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic [TAGW-1:0] tag,
  output ex_ctrl_t        ctrl
);

  logic [3:0] map_s;
  ex_ctrl_t   ctrl_s;

  // Opcode-driven decode of the ALU operation and companion control bits.
  always_comb begin
    ctrl_s     = '0;
    ctrl_s.tag = TAG_MAXW'(tag);
    map_s      = 4'b0000;
    case (op)
      OP_R: begin
        map_s = funct3_to_alu(funct3, funct7b5);
        if (map_s[3]) begin
          ctrl_s.alucontrol = map_s[2:0];
          ctrl_s.regwrite   = 1'b1;
        end else begin
          ctrl_s.illegal    = 1'b1;
        end
      end
      OP_I: begin
        // funct7b5 is part of the immediate here, never a sub select.
        map_s = funct3_to_alu(funct3, 1'b0);
        if (map_s[3]) begin
          ctrl_s.alucontrol = map_s[2:0];
          ctrl_s.alusrc_imm = 1'b1;
          ctrl_s.regwrite   = 1'b1;
        end else begin
          ctrl_s.illegal    = 1'b1;
        end
      end
      OP_LOAD: begin
        ctrl_s.alucontrol = ALU_ADD;
        ctrl_s.alusrc_imm = 1'b1;
        ctrl_s.regwrite   = 1'b1;
      end
      OP_STORE: begin
        ctrl_s.alucontrol = ALU_ADD;
        ctrl_s.alusrc_imm = 1'b1;
      end
      OP_BRANCH: begin
        ctrl_s.alucontrol = ALU_SUB;
        ctrl_s.branch     = 1'b1;
      end
      default: begin
        ctrl_s.illegal    = 1'b1;
      end
    endcase
  end

  assign ctrl = ctrl_s;

endmodule

// File: rtl/alu_ctrl_issue.sv
// -----------------------------------------------------------------------------
// alu_ctrl_issue
// Decodes an ID-stage instruction into the EX-stage ALU control word and
// registers it through a 2-entry skid buffer at the ID/EX boundary.
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   in_valid / in_ready   ID-side handshake (in_ready is a pure register)
//   op, funct3, funct7b5  instruction fields to decode
//   in_tag  [TAGW-1:0]    opaque tag carried unmodified
//   flush                 drop every held entry and the input of this cycle
//   out_valid / out_ready EX-side handshake
//   alucontrol [2:0]      000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
//   alusrc_imm, regwrite, branch, out_tag  companion EX controls
//   illegal               only when ALU_CTRL_ILLEGAL_EN is defined
// Configuration macro: ALU_CTRL_ILLEGAL_EN (adds the registered illegal port).
// Main register M drives the outputs; skid register S catches an input
// accepted while M is stalled. An invalid M is held at all-zero payload, so
// regwrite/branch/illegal read 0 whenever out_valid=0.
// -----------------------------------------------------------------------------
module alu_ctrl_issue
  import riscv_pkg::*;
#(
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      op,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic [TAGW-1:0] in_tag,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      alucontrol,
  output logic            alusrc_imm,
  output logic            regwrite,
  output logic            branch,
  output logic [TAGW-1:0] out_tag
`ifdef ALU_CTRL_ILLEGAL_EN
  ,
  output logic            illegal
`endif
);

  ex_ctrl_t dec_s;
  ex_ctrl_t m_r;
  ex_ctrl_t s_r;
  logic     m_valid_r;
  logic     s_valid_r;
  logic     in_ready_r;
  logic     in_fire_s;
  logic     out_fire_s;

  alu_ctrl_dec #(.TAGW(TAGW)) u_dec (
    .op       (op),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .tag      (in_tag),
    .ctrl     (dec_s)
  );

  assign in_fire_s  = in_valid & in_ready_r;
  assign out_fire_s = m_valid_r & out_ready;

  // Skid buffer: M/S payload and valid bits, plus the registered in_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_r        <= '0;
      s_r        <= '0;
      m_valid_r  <= 1'b0;
      s_valid_r  <= 1'b0;
      in_ready_r <= 1'b1;
    end else if (flush) begin
      // Flush wins over every transfer, including this cycle's input.
      m_r        <= '0;
      s_r        <= '0;
      m_valid_r  <= 1'b0;
      s_valid_r  <= 1'b0;
      in_ready_r <= 1'b1;
    end else if (out_fire_s || !m_valid_r) begin
      // M is free this cycle: refill from S first to keep FIFO order.
      if (s_valid_r) begin
        m_r        <= s_r;
        m_valid_r  <= 1'b1;
        s_r        <= '0;
        s_valid_r  <= 1'b0;
        in_ready_r <= 1'b1;
      end else if (in_fire_s) begin
        m_r        <= dec_s;
        m_valid_r  <= 1'b1;
      end else begin
        m_r        <= '0;
        m_valid_r  <= 1'b0;
      end
    end else if (in_fire_s) begin
      // M is stalled: park the accepted op in S and close the input.
      s_r        <= dec_s;
      s_valid_r  <= 1'b1;
      in_ready_r <= 1'b0;
    end else begin
      m_valid_r  <= m_valid_r;
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = m_valid_r;
  assign alucontrol = m_r.alucontrol;
  assign alusrc_imm = m_r.alusrc_imm;
  assign regwrite   = m_r.regwrite;
  assign branch     = m_r.branch;
  assign out_tag    = m_r.tag[TAGW-1:0];

  // Tag slot bits above TAGW are always zero and intentionally unread.
  logic [TAG_MAXW-1:0] unused_tag_s;
  assign unused_tag_s = m_r.tag;

`ifdef ALU_CTRL_ILLEGAL_EN
  assign illegal = m_r.illegal;
`else
  logic unused_ill_s;
  assign unused_ill_s = m_r.illegal;
`endif

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl_issue
// Self-checking bench: directed scenarios plus randomized traffic, compared
// against a queue-based reference model of a 2-deep in-order buffer.
// -----------------------------------------------------------------------------
module tb_alu_ctrl_issue;

  localparam int TAGW = 5;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      op;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic [TAGW-1:0] in_tag;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [2:0]      alucontrol;
  logic            alusrc_imm;
  logic            regwrite;
  logic            branch;
  logic [TAGW-1:0] out_tag;
  logic            ill_obs;
`ifdef ALU_CTRL_ILLEGAL_EN
  logic            illegal;
  assign ill_obs = illegal;
`else
  assign ill_obs = 1'b0;
`endif

  alu_ctrl_issue #(.TAGW(TAGW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .in_tag     (in_tag),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alucontrol (alucontrol),
    .alusrc_imm (alusrc_imm),
    .regwrite   (regwrite),
    .branch     (branch),
    .out_tag    (out_tag)
`ifdef ALU_CTRL_ILLEGAL_EN
    ,
    .illegal    (illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]      alu;
    logic            imm;
    logic            wr;
    logic            br;
    logic            ill;
    logic [TAGW-1:0] tag;
  } exp_t;

  exp_t q[$];
  int   vecs = 0;
  int   errs = 0;

  // Observed word: [13]valid [12]ready [11:9]alu [8]imm [7]wr [6]br [5]ill [4:0]tag
  logic [13:0] obs_w;
  assign obs_w = {out_valid, in_ready, alucontrol, alusrc_imm, regwrite, branch, ill_obs, out_tag};

  // Reference decode from the instruction-class table.
  function automatic exp_t ref_decode(input logic [6:0] o, input logic [2:0] f3,
                                      input logic f7, input logic [TAGW-1:0] t);
    exp_t        e;
    logic [23:0] alu_tbl;
    logic [7:0]  legal_tbl;
    alu_tbl   = {3'd2, 3'd3, 3'd0, 3'd4, 3'd0, 3'd5, 3'd0, 3'd0};
    legal_tbl = 8'b1101_0101;
    e = '0;
    e.tag = t;
    if (o == 7'h33 || o == 7'h13) begin
      if (legal_tbl[f3]) begin
        e.alu = alu_tbl[int'(f3)*3 +: 3];
        if (o == 7'h33 && f3 == 3'd0 && f7) e.alu = 3'd1;
        e.imm = (o == 7'h13);
        e.wr  = 1'b1;
      end else begin
        e.ill = 1'b1;
      end
    end else if (o == 7'h03) begin
      e.imm = 1'b1;
      e.wr  = 1'b1;
    end else if (o == 7'h23) begin
      e.imm = 1'b1;
    end else if (o == 7'h63) begin
      e.alu = 3'd1;
      e.br  = 1'b1;
    end else begin
      e.ill = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [13:0] exp_word();
    exp_t e;
    e = '0;
    if (q.size() > 0) e = q[0];
    return {(q.size() > 0), (q.size() < 2), e};
  endfunction

  // Fields the spec leaves open are excluded from comparison.
  function automatic logic [13:0] cmp_mask();
    logic [13:0] m;
    m = 14'h3fff;
    if (q.size() == 0) m = 14'b11_000_0111_00000;
    else if (q[0].ill) m[8] = 1'b0;
`ifndef ALU_CTRL_ILLEGAL_EN
    m[5] = 1'b0;
`endif
    return m;
  endfunction

  task automatic put(input logic v, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic [TAGW-1:0] t);
    in_valid = v;
    op       = o;
    funct3   = f3;
    funct7b5 = f7;
    in_tag   = t;
  endtask

  // Advance one clock and step the reference model with the applied inputs.
  task automatic tick();
    bit of;
    bit inf;
    @(posedge clk);
    of  = (q.size() > 0) && out_ready;
    inf = in_valid && (q.size() < 2);
    if (flush) begin
      q.delete();
    end else begin
      if (of) void'(q.pop_front());
      if (inf) q.push_back(ref_decode(op, funct3, funct7b5, in_tag));
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    put(1'b0, 7'h00, 3'd0, 1'b0, 5'd0);
    #12;
    reset = 1'b0;
    q.delete();
    #1;
    vecs++;
    if (obs_w !== 14'b01_000_0000_00000) begin
      errs++; $display("FAIL reset_state got=%b exp=%b", obs_w, 14'b01_000_0000_00000);
    end
  endtask

  task automatic test_rtype_sub();
    out_ready = 1'b1;
    put(1'b1, 7'h33, 3'd0, 1'b1, 5'd7);
    tick();
    put(1'b0, 7'h00, 3'd0, 1'b0, 5'd0);
    vecs++;
    if ({out_valid, alucontrol, regwrite, out_tag} !== {1'b1, 3'b001, 1'b1, 5'd7}) begin
      errs++; $display("FAIL rtype_sub got v=%b alu=%b wr=%b tag=%0d exp v=1 alu=001 wr=1 tag=7",
                       out_valid, alucontrol, regwrite, out_tag);
    end
    tick();
    vecs++;
    if ((obs_w & cmp_mask()) !== (exp_word() & cmp_mask())) begin
      errs++; $display("FAIL rtype_drain got=%b exp=%b", obs_w, exp_word());
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] want [3];
    want[0] = {3'b100, 1'b1, 1'b1, 1'b0};
    want[1] = {3'b000, 1'b1, 1'b1, 1'b0};
    want[2] = {3'b001, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    put(1'b1, 7'h13, 3'd4, 1'b0, 5'd1);
    tick();
    put(1'b1, 7'h03, 3'd2, 1'b0, 5'd2);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        tick();
        put(1'b1, 7'h63, 3'd1, 1'b0, 5'd3);
      end else if (i == 2) begin
        tick();
        put(1'b0, 7'h00, 3'd0, 1'b0, 5'd0);
      end
      vecs++;
      if ({out_valid, alucontrol, alusrc_imm, regwrite, branch, out_tag} !==
          {1'b1, want[i], 5'(i + 1)}) begin
        errs++; $display("FAIL b2b_op%0d got v=%b alu=%b imm=%b wr=%b br=%b tag=%0d exp ctl=%b tag=%0d",
                         i, out_valid, alucontrol, alusrc_imm, regwrite, branch, out_tag, want[i], i + 1);
      end
    end
    tick();
    vecs++;
    if ((obs_w & cmp_mask()) !== (exp_word() & cmp_mask())) begin
      errs++; $display("FAIL b2b_drain got=%b exp=%b", obs_w, exp_word());
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    put(1'b1, 7'h13, 3'd7, 1'b0, 5'd11);
    tick();
    put(1'b1, 7'h33, 3'd6, 1'b0, 5'd12);
    tick();
    vecs++;
    if ({in_ready, out_valid, out_tag, alucontrol} !== {1'b0, 1'b1, 5'd11, 3'b010}) begin
      errs++; $display("FAIL bp_full got rdy=%b v=%b tag=%0d alu=%b exp rdy=0 v=1 tag=11 alu=010",
                       in_ready, out_valid, out_tag, alucontrol);
    end
    put(1'b1, 7'h33, 3'd4, 1'b0, 5'd13);
    tick();
    vecs++;
    if ({in_ready, out_tag} !== {1'b0, 5'd11}) begin
      errs++; $display("FAIL bp_hold got rdy=%b tag=%0d exp rdy=0 tag=11", in_ready, out_tag);
    end
    put(1'b0, 7'h00, 3'd0, 1'b0, 5'd0);
    out_ready = 1'b1;
    tick();
    vecs++;
    if ({in_ready, out_valid, out_tag, alucontrol} !== {1'b1, 1'b1, 5'd12, 3'b011}) begin
      errs++; $display("FAIL bp_drain2 got rdy=%b v=%b tag=%0d alu=%b exp rdy=1 v=1 tag=12 alu=011",
                       in_ready, out_valid, out_tag, alucontrol);
    end
    tick();
    vecs++;
    if ((obs_w & cmp_mask()) !== (exp_word() & cmp_mask()) || out_valid !== 1'b0) begin
      errs++; $display("FAIL bp_empty got=%b exp=%b", obs_w, exp_word());
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    put(1'b1, 7'h03, 3'd0, 1'b0, 5'd21);
    tick();
    put(1'b1, 7'h23, 3'd0, 1'b0, 5'd22);
    tick();
    put(1'b1, 7'h33, 3'd0, 1'b0, 5'd31);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    put(1'b0, 7'h00, 3'd0, 1'b0, 5'd0);
    vecs++;
    if ({out_valid, in_ready, regwrite, branch} !== 4'b0100) begin
      errs++; $display("FAIL flush got v=%b rdy=%b wr=%b br=%b exp v=0 rdy=1 wr=0 br=0",
                       out_valid, in_ready, regwrite, branch);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vecs++;
      if (out_valid !== 1'b0) begin
        errs++; $display("FAIL flush_ghost%0d got v=%b tag=%0d exp v=0", i, out_valid, out_tag);
      end
    end
  endtask

  task automatic test_illegal();
    logic [6:0] ops [2];
    logic [2:0] f3s [2];
    ops[0] = 7'h7f; f3s[0] = 3'd0;
    ops[1] = 7'h33; f3s[1] = 3'd1;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      put(1'b1, ops[i], f3s[i], 1'b0, 5'(20 + i));
      tick();
      put(1'b0, 7'h00, 3'd0, 1'b0, 5'd0);
      vecs++;
      if ({out_valid, alucontrol, regwrite, branch} !== {1'b1, 3'b000, 1'b0, 1'b0}) begin
        errs++; $display("FAIL illegal%0d got v=%b alu=%b wr=%b br=%b exp v=1 alu=000 wr=0 br=0",
                         i, out_valid, alucontrol, regwrite, branch);
      end
`ifdef ALU_CTRL_ILLEGAL_EN
      vecs++;
      if (illegal !== 1'b1) begin
        errs++; $display("FAIL illegal_flag%0d got=%b exp=1", i, illegal);
      end
`endif
    end
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    put(1'b1, 7'h33, 3'd7, 1'b0, 5'd9);
    tick();
    put(1'b0, 7'h00, 3'd0, 1'b0, 5'd0);
    vecs++;
    if (out_valid !== 1'b1) begin
      errs++; $display("FAIL arst_pre got v=%b exp v=1", out_valid);
    end
    #2 reset = 1'b1;
    #1;
    vecs++;
    if ({out_valid, in_ready, regwrite, branch} !== 4'b0100) begin
      errs++; $display("FAIL arst_async got v=%b rdy=%b wr=%b br=%b exp v=0 rdy=1 wr=0 br=0",
                       out_valid, in_ready, regwrite, branch);
    end
    q.delete();
    #1 reset = 1'b0;
    tick();
    vecs++;
    if ((obs_w & cmp_mask()) !== (exp_word() & cmp_mask())) begin
      errs++; $display("FAIL arst_post got=%b exp=%b", obs_w, exp_word());
    end
  endtask

  task automatic test_random();
    logic [6:0] op_tbl [6];
    op_tbl[0] = 7'h33; op_tbl[1] = 7'h13; op_tbl[2] = 7'h03;
    op_tbl[3] = 7'h23; op_tbl[4] = 7'h63; op_tbl[5] = 7'h00;
    for (int i = 0; i < 400; i++) begin
      int k;
      k = int'($urandom_range(0, 5));
      put(($urandom_range(0, 3) != 0),
          (k == 5) ? 7'($urandom) : op_tbl[k],
          3'($urandom), 1'($urandom), 5'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      tick();
      vecs++;
      if ((obs_w & cmp_mask()) !== (exp_word() & cmp_mask())) begin
        errs++; $display("FAIL random cyc=%0d got=%b exp=%b mask=%b", i, obs_w, exp_word(), cmp_mask());
      end
    end
    flush = 1'b0;
    put(1'b0, 7'h00, 3'd0, 1'b0, 5'd0);
  endtask

  initial begin
    test_reset();
    test_rtype_sub();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_illegal();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
